// File: rtl/csr_file.sv
// Machine-mode CSR unit: cycle/instret/event counters, trap state and the
// CSRRW/CSRRS/CSRRC read-modify-write path, with combinational read data.
module csr_file #(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     NUM_HPM   = 2,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(64'h8000_0000)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [11:0]                             csr_addr,
  input  logic                                    csr_rena,
  input  logic                                    csr_wena,
  input  logic [1:0]                              csr_op,
  input  logic [XLEN-1:0]                         rs1_data,
  output logic [XLEN-1:0]                         csr_data,
  output logic                                    csr_illegal,
  input  logic                                    inst_retire,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic                                    trap_valid,
  input  logic [XLEN-1:0]                         trap_pc,
  input  logic [XLEN-1:0]                         trap_cause,
  input  logic                                    mret,
  output logic [XLEN-1:0]                         trap_vec,
  output logic [XLEN-1:0]                         epc,
  output logic                                    mie
);

  localparam int unsigned     HPM_N      = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [1:0]      CSR_RW     = 2'b01;
  localparam logic [1:0]      CSR_RS     = 2'b10;
  localparam logic [1:0]      CSR_RC     = 2'b11;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] mcycle_q,   mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
  logic [XLEN-1:0] hpm_q [HPM_N];
  logic [XLEN-1:0] hpm_d [HPM_N];
  logic [XLEN-1:0] mtvec_q,    mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q,     mepc_d;
  logic [XLEN-1:0] mcause_q,   mcause_d;
  logic            mie_q,      mie_d;
  logic            mpie_q,     mpie_d;

  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] wdata;
  logic            hit;
  logic            read_only;
  logic            wr_en;

  // Address decode and raw read value; rdata is also the "old" value for RS/RC.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    rdata = '0;
    hit   = 1'b0;
    case (csr_addr)
      12'h300: begin
        hit         = 1'b1;
        rdata[3]    = mie_q;
        rdata[7]    = mpie_q;
        rdata[12:11] = 2'b11;
      end
      12'h305:          begin hit = 1'b1; rdata = mtvec_q;    end
      12'h340:          begin hit = 1'b1; rdata = mscratch_q; end
      12'h341:          begin hit = 1'b1; rdata = mepc_q;     end
      12'h342:          begin hit = 1'b1; rdata = mcause_q;   end
      12'hB00, 12'hC00: begin hit = 1'b1; rdata = mcycle_q;   end
      12'hB02, 12'hC02: begin hit = 1'b1; rdata = minstret_q; end
      default: ;
    endcase
    for (int i = 0; i < int'(NUM_HPM); i++) begin
      if (csr_addr == 12'(12'hB03 + i) || csr_addr == 12'(12'hC03 + i)) begin
        hit   = 1'b1;
        rdata = hpm_q[i];
      end
    end
  end

  assign read_only   = hit && (csr_addr[11:8] == 4'hC);
  assign csr_illegal = (csr_rena | csr_wena) & (~hit | (csr_wena & read_only));
  assign csr_data    = (csr_rena && !csr_illegal) ? rdata : '0;
  assign wr_en       = csr_wena && !csr_illegal && (csr_op != 2'b00);

  always_comb begin
    case (csr_op)
      CSR_RW:  wdata = rs1_data;
      CSR_RS:  wdata = rdata | rs1_data;
      CSR_RC:  wdata = rdata & ~rs1_data;
      default: wdata = rdata;
    endcase
  end

  // Next state: counters count, a CSR write overrides, trap/mret override the write.
  always_comb begin
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = minstret_q + XLEN'(inst_retire);
    for (int i = 0; i < int'(HPM_N); i++) begin
      hpm_d[i] = hpm_q[i];
    end
    for (int i = 0; i < int'(NUM_HPM); i++) begin
      hpm_d[i] = hpm_q[i] + XLEN'(hpm_event[i]);
    end
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;

    if (wr_en) begin
      case (csr_addr)
        12'h300: begin
          mie_d  = wdata[3];
          mpie_d = wdata[7];
        end
        12'h305: mtvec_d    = wdata & ALIGN_MASK;
        12'h340: mscratch_d = wdata;
        12'h341: mepc_d     = wdata & ALIGN_MASK;
        12'h342: mcause_d   = wdata;
        12'hB00: mcycle_d   = wdata;
        12'hB02: minstret_d = wdata;
        default: ;
      endcase
      for (int i = 0; i < int'(NUM_HPM); i++) begin
        if (csr_addr == 12'(12'hB03 + i)) hpm_d[i] = wdata;
      end
    end

    if (trap_valid) begin
      mepc_d   = trap_pc & ALIGN_MASK;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      // NOTE: the counter array is plain flops, not a RAM, so resetting every entry is cheap and required.
      for (int i = 0; i < int'(HPM_N); i++) begin
        hpm_q[i] <= '0;
      end
      mtvec_q    <= RESET_VEC & ALIGN_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      for (int i = 0; i < int'(HPM_N); i++) begin
        hpm_q[i] <= hpm_d[i];
      end
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
    end
  end

  assign trap_vec = mtvec_q;
  assign epc      = mepc_q;
  assign mie      = mie_q;

endmodule
